// File: rtl/instruction_loader.sv
`timescale 1ns/1ps
// Assembles a little-endian byte stream into instruction words and writes them to instruction memory.
// Optional running checksum of written words: define LOADER_CHECKSUM_EN.
module instruction_loader #(
  parameter int INST_MAX_LENGTH = 32,
  parameter int REG_MAX_LENGTH  = 32,
  parameter int MAX_WORDS       = 256
) (
  input  logic                       Clk,
  input  logic                       ResetN,
  input  logic                       Start,
  input  logic [REG_MAX_LENGTH-1:0]  Length,
  input  logic [7:0]                 ByteIn,
  input  logic                       ByteValid,
  output logic                       ByteReady,
  output logic                       WriteEnable,
  output logic [REG_MAX_LENGTH-1:0]  WriteAddress,
  output logic [INST_MAX_LENGTH-1:0] WriteData,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Error,
  output logic [INST_MAX_LENGTH-1:0] Checksum
);

  localparam int BYTES = INST_MAX_LENGTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [REG_MAX_LENGTH-1:0] MAX_LEN  = REG_MAX_LENGTH'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;

  state_t                     state_q, state_d;
  logic [REG_MAX_LENGTH-1:0]  count_q, count_d;
  logic [REG_MAX_LENGTH-1:0]  addr_q, addr_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [INST_MAX_LENGTH-1:0] data_q, data_d;
  logic                       error_q, error_d;
  logic                       start_ok;

  assign start_ok = (state_q == IDLE) && Start && (Length != '0) && (Length <= MAX_LEN);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    data_d  = data_q;
    error_d = error_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          if (start_ok) begin
            error_d = 1'b0;
            count_d = Length;
            addr_d  = '0;
            idx_d   = '0;
            state_d = COLLECT;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (ByteValid) begin
          // Byte lane k of the word receives the k-th byte of the stream.
          for (int k = 0; k < BYTES; k++) begin
            if (idx_q == IDX_W'(k)) data_d[8*k +: 8] = ByteIn;
          end
          if (idx_q == LAST_IDX) state_d = WRITE;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      WRITE: begin
        addr_d  = addr_q + REG_MAX_LENGTH'(4);
        count_d = count_q - REG_MAX_LENGTH'(1);
        idx_d   = '0;
        state_d = (count_q == REG_MAX_LENGTH'(1)) ? FINISH : COLLECT;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      error_q <= error_d;
    end
  end

  // Strobes decode straight from the state register, so reset clears them at once.
  assign ByteReady    = (state_q == COLLECT);
  assign WriteEnable  = (state_q == WRITE);
  assign Busy         = (state_q != IDLE);
  assign Done         = (state_q == FINISH);
  assign WriteAddress = addr_q;
  assign WriteData    = data_q;
  assign Error        = error_q;

`ifdef LOADER_CHECKSUM_EN
  logic [INST_MAX_LENGTH-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (start_ok)                checksum_d = '0;
    else if (state_q == WRITE)   checksum_d = checksum_q + data_q;
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) checksum_q <= '0;
    else         checksum_q <= checksum_d;
  end

  assign Checksum = checksum_q;
`else
  assign Checksum = '0;
`endif

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The module SHALL have parameter INST_MAX_LENGTH, default 32, giving the instruction word width in bits.
REQ-002 The module SHALL have parameter REG_MAX_LENGTH, default 32, giving the address and length width in bits.
REQ-003 The module SHALL have parameter MAX_WORDS, default 256, giving the maximum number of words per load.
REQ-004 The module SHALL have a single clock; its reset SHALL be asynchronous and active-low.
REQ-005 Port Clk  input  1  clock; all state updates on the rising edge.
REQ-006 Port ResetN  input  1  asynchronous active-low reset.
REQ-007 Port Start  input  1  one-cycle request to begin a load.
REQ-008 Port Length  input  REG_MAX_LENGTH  number of words to load, sampled when Start is accepted.
REQ-009 Port ByteIn  input  8  program byte stream.
REQ-010 Port ByteValid  input  1  ByteIn holds a valid byte.
REQ-011 Port ByteReady  output  1  loader accepts a byte this cycle.
REQ-012 Port WriteEnable  output  1  instruction memory write strobe.
REQ-013 Port WriteAddress  output  REG_MAX_LENGTH  byte address of the word being written.
REQ-014 Port WriteData  output  INST_MAX_LENGTH  assembled instruction word.
REQ-015 Port Busy  output  1  a load is in progress.
REQ-016 Port Done  output  1  one-cycle pulse on load completion.
REQ-017 Port Error  output  1  sticky flag: last Start was rejected.
REQ-018 Port Checksum  output  INST_MAX_LENGTH  running sum of written words (see Configuration).

Function
REQ-019 The FSM SHALL have exactly the states IDLE, COLLECT, WRITE and FINISH.
REQ-020 In IDLE, if Start=1 and 1<=Length<=MAX_WORDS, the loader SHALL clear Error, set the word counter to Length, set the address to 0, set the byte index to 0, and enter COLLECT.
REQ-021 In IDLE, if Start=1 and Length is 0 or greater than MAX_WORDS, the loader SHALL set Error and remain in IDLE.
REQ-022 The loader SHALL ignore Start in any state other than IDLE.
REQ-023 ByteReady SHALL be 1 only in COLLECT; a byte transfers on an edge where ByteValid=1 and ByteReady=1.
REQ-024 Bytes SHALL be assembled little-endian: byte index k SHALL be placed in WriteData[8k+7:8k].
REQ-025 If ByteValid is low in COLLECT, the loader SHALL stall with no state change.
REQ-026 On the edge that accepts byte index 3, the loader SHALL enter WRITE, so WriteEnable=1 in the following cycle (one-cycle latency).
REQ-027 In WRITE, WriteEnable SHALL be 1 for exactly one cycle with stable WriteAddress and WriteData.
REQ-028 On leaving WRITE, the loader SHALL increment WriteAddress by 4 (modulo 2^REG_MAX_LENGTH), decrement the word counter, and reset the byte index to 0.
REQ-029 On leaving WRITE, the loader SHALL enter FINISH if the word counter was 1 and COLLECT otherwise.
REQ-030 In FINISH, Done SHALL be 1 for one cycle, after which the loader SHALL return to IDLE.
REQ-031 Busy SHALL be 1 in COLLECT, WRITE and FINISH, and 0 in IDLE.
REQ-032 WriteEnable SHALL be 0 in every state other than WRITE; a partially collected word SHALL never be written.

Reset
REQ-033 Asserting ResetN=0 SHALL immediately force IDLE and clear ByteReady, WriteEnable, WriteAddress, WriteData, Busy, Done, Error, Checksum and all counters to 0.
REQ-034 Reset asserted mid-load SHALL abort the load with no further write, and the loader SHALL require a new Start after release.

Configuration
REQ-035 When the macro LOADER_CHECKSUM_EN is defined, Checksum SHALL be cleared on an accepted Start and SHALL add WriteData, modulo 2^INST_MAX_LENGTH, on each WRITE cycle, with the updated value visible from the next cycle.
REQ-036 When LOADER_CHECKSUM_EN is not defined, the Checksum port SHALL be present and tied to 0, and no accumulator logic SHALL be built.

Verification
REQ-037 Start, Length=1, bytes 13,00,00,00 -> one WriteEnable with WriteAddress=0x0 and WriteData=0x00000013, then a one-cycle Done pulse, then Busy=0.
REQ-038 Start, Length=2, bytes 93,00,10,00,13,01,20,00 -> writes 0x00100093 at address 0x0 and 0x00200113 at address 0x4; Checksum=0x003001A6 when LOADER_CHECKSUM_EN is defined, 0 otherwise.
REQ-039 Length=0 and Length=257 with Start -> Error=1, Busy=0, no write; a following valid Start clears Error.
REQ-040 ByteValid deasserted for 5 cycles between bytes 1 and 2 -> no state change while stalled, and the correct word is written afterwards.
REQ-041 ResetN pulsed low after 2 bytes of a word -> all outputs 0 immediately, no WriteEnable, and Start is required to resume.
REQ-042 Start pulsed during COLLECT -> ignored; the counter and address are unchanged.
